// File: rtl/niu_sii_req_sched.sv
// niu_sii_req_sched
// Schedules inbound DMA requests from the NIU onto the shared niu_sii bus.
// Two requesters (ordered queue "oq", bypass queue "bq") compete for the bus.
// Each granted request becomes one header cycle; writes are followed by
// payload beats (4 for a 64B write, 1 for a 16B write). Per-queue SII credits
// are tracked here, and a bypass streak counter prevents oq starvation.
//
// Ports
//   iol2clk, rst_l             clock, async active-low reset
//   {oq,bq}_req/_wr/_len16     request level and attributes, held until gnt
//   {oq,bq}_hdr/_be/_pld       header, write byte enables, current payload beat
//   {oq,bq}_gnt                grant (comb): header consumed at this edge
//   {oq,bq}_pld_pop            pop (comb): current beat consumed at this edge
//   sii_niu_{oq,bq}dq          one-cycle credit return pulses
//   niu_sii_*                  registered bus outputs (header/payload, parity, be)
//   credit_err                 sticky: credit returned while counter already full
//   dbg_state                  FSM state (0=IDLE, 1=PLD)
//   dbg_oq_credit/bq_credit    current credit counters
//   dbg_byp_streak             consecutive bypass grants while oq was eligible
//
// Handshake: a requester holds x_req plus its attributes until x_gnt is seen
// high at a rising edge; the header is taken at that edge. For writes, x_pld
// must present the current beat from the grant until the final pop; each edge
// where x_pld_pop is high consumes that beat and the requester advances.
module niu_sii_req_sched #(
  parameter int OQ_CREDITS = 16,
  parameter int BQ_CREDITS = 16,
  parameter int BYP_LIMIT  = 4
) (
  input  logic         iol2clk,
  input  logic         rst_l,
  input  logic         oq_req,
  input  logic         oq_wr,
  input  logic         oq_len16,
  input  logic [127:0] oq_hdr,
  input  logic [15:0]  oq_be,
  input  logic [127:0] oq_pld,
  input  logic         bq_req,
  input  logic         bq_wr,
  input  logic         bq_len16,
  input  logic [127:0] bq_hdr,
  input  logic [15:0]  bq_be,
  input  logic [127:0] bq_pld,
  output logic         oq_gnt,
  output logic         bq_gnt,
  output logic         oq_pld_pop,
  output logic         bq_pld_pop,
  input  logic         sii_niu_oqdq,
  input  logic         sii_niu_bqdq,
  output logic         niu_sii_hdr_vld,
  output logic         niu_sii_reqbypass,
  output logic         niu_sii_datareq,
  output logic         niu_sii_datareq16,
  output logic [127:0] niu_sii_data,
  output logic [7:0]   niu_sii_parity,
  output logic [15:0]  niu_sii_be,
  output logic         credit_err,
  output logic         dbg_state,
  output logic [4:0]   dbg_oq_credit,
  output logic [4:0]   dbg_bq_credit,
  output logic [3:0]   dbg_byp_streak
);

  typedef enum logic {IDLE = 1'b0, PLD = 1'b1} state_t;

  localparam logic [4:0] OQ_MAX  = 5'(OQ_CREDITS);
  localparam logic [4:0] BQ_MAX  = 5'(BQ_CREDITS);
  localparam logic [3:0] BYP_MAX = 4'(BYP_LIMIT);

  state_t     state;
  logic [2:0] beats_left;
  logic       pld_bq;      // payload in flight belongs to bq
  logic [3:0] byp_streak;
  logic [4:0] oq_cnt;
  logic [4:0] bq_cnt;

  logic         oq_elig, bq_elig, byp_capped, any_gnt;
  logic         g_wr, g_len16;
  logic [127:0] g_hdr;
  logic [15:0]  g_be;

  logic         hv_nxt, byp_nxt, dr_nxt, dr16_nxt;
  logic [127:0] data_nxt;
  logic [15:0]  be_nxt;
  logic [7:0]   par_nxt;

  // Arbitration only happens while IDLE; PLD returns to IDLE on the last pop,
  // so the cycle after the last pop is an arbitration cycle.
  assign oq_elig    = oq_req && (oq_cnt != 5'd0);
  assign bq_elig    = bq_req && (bq_cnt != 5'd0);
  assign byp_capped = (byp_streak == BYP_MAX) && oq_elig;
  assign bq_gnt     = (state == IDLE) && bq_elig && !byp_capped;
  assign oq_gnt     = (state == IDLE) && oq_elig && !(bq_elig && !byp_capped);
  assign any_gnt    = oq_gnt || bq_gnt;

  assign oq_pld_pop = (state == PLD) && !pld_bq;
  assign bq_pld_pop = (state == PLD) && pld_bq;

  assign g_wr    = bq_gnt ? bq_wr    : oq_wr;
  assign g_len16 = bq_gnt ? bq_len16 : oq_len16;
  assign g_hdr   = bq_gnt ? bq_hdr   : oq_hdr;
  assign g_be    = bq_gnt ? bq_be    : oq_be;

  always_comb begin
    hv_nxt   = 1'b0;
    byp_nxt  = 1'b0;
    dr_nxt   = 1'b0;
    dr16_nxt = 1'b0;
    be_nxt   = 16'h0;
    data_nxt = 128'h0;
    if (any_gnt) begin
      hv_nxt   = 1'b1;
      byp_nxt  = bq_gnt;
      dr_nxt   = g_wr && !g_len16;
      dr16_nxt = g_wr && g_len16;
      be_nxt   = g_wr ? g_be : 16'h0;
      data_nxt = g_hdr;
    end else if (oq_pld_pop) begin
      data_nxt = oq_pld;
    end else if (bq_pld_pop) begin
      data_nxt = bq_pld;
    end
  end

  always_comb begin
    par_nxt = 8'h0;
    for (int i = 0; i < 8; i++) par_nxt[i] = ^data_nxt[16*i +: 16];
  end

  // FSM: beat sequencing and bypass streak
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= IDLE;
      beats_left <= 3'd0;
      pld_bq     <= 1'b0;
      byp_streak <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_gnt && g_wr) begin
            state      <= PLD;
            beats_left <= g_len16 ? 3'd1 : 3'd4;
            pld_bq     <= bq_gnt;
          end
        end
        PLD: begin
          beats_left <= beats_left - 3'd1;
          if (beats_left == 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (bq_gnt) byp_streak <= oq_elig ? byp_streak + 4'd1 : 4'd0;
      else if (oq_gnt) byp_streak <= 4'd0;
    end
  end

  // Credits: a grant and a return in the same cycle cancel out.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      oq_cnt     <= OQ_MAX;
      bq_cnt     <= BQ_MAX;
      credit_err <= 1'b0;
    end else begin
      if (oq_gnt && !sii_niu_oqdq) oq_cnt <= oq_cnt - 5'd1;
      else if (sii_niu_oqdq && !oq_gnt && oq_cnt != OQ_MAX) oq_cnt <= oq_cnt + 5'd1;
      if (bq_gnt && !sii_niu_bqdq) bq_cnt <= bq_cnt - 5'd1;
      else if (sii_niu_bqdq && !bq_gnt && bq_cnt != BQ_MAX) bq_cnt <= bq_cnt + 5'd1;
      if ((sii_niu_oqdq && !oq_gnt && oq_cnt == OQ_MAX) ||
          (sii_niu_bqdq && !bq_gnt && bq_cnt == BQ_MAX))
        credit_err <= 1'b1;
    end
  end

  // Registered bus outputs; parity and be travel with data.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      niu_sii_hdr_vld   <= 1'b0;
      niu_sii_reqbypass <= 1'b0;
      niu_sii_datareq   <= 1'b0;
      niu_sii_datareq16 <= 1'b0;
      niu_sii_data      <= 128'h0;
      niu_sii_parity    <= 8'h0;
      niu_sii_be        <= 16'h0;
    end else begin
      niu_sii_hdr_vld   <= hv_nxt;
      niu_sii_reqbypass <= byp_nxt;
      niu_sii_datareq   <= dr_nxt;
      niu_sii_datareq16 <= dr16_nxt;
      niu_sii_data      <= data_nxt;
      niu_sii_parity    <= par_nxt;
      niu_sii_be        <= be_nxt;
    end
  end

  assign dbg_state      = state;
  assign dbg_oq_credit  = oq_cnt;
  assign dbg_bq_credit  = bq_cnt;
  assign dbg_byp_streak = byp_streak;

endmodule

// File: tb/tb_niu_sii_req_sched.sv
// Bench for niu_sii_req_sched. Each cycle the bench pushes the bus word it
// expects one edge later onto exp_q; the scoreboard step pops and compares
// after every rising edge. Grant/pop levels are checked inline per task.
module tb_niu_sii_req_sched;

  logic         iol2clk, rst_l;
  logic         oq_req, oq_wr, oq_len16, bq_req, bq_wr, bq_len16;
  logic [127:0] oq_hdr, oq_pld, bq_hdr, bq_pld;
  logic [15:0]  oq_be, bq_be;
  logic         oq_gnt, bq_gnt, oq_pld_pop, bq_pld_pop;
  logic         sii_niu_oqdq, sii_niu_bqdq;
  logic         niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16;
  logic [127:0] niu_sii_data;
  logic [7:0]   niu_sii_parity;
  logic [15:0]  niu_sii_be;
  logic         credit_err, dbg_state;
  logic [4:0]   dbg_oq_credit, dbg_bq_credit;
  logic [3:0]   dbg_byp_streak;

  int n_checks = 0;
  int n_fail   = 0;
  logic [147:0] exp_q[$];

  niu_sii_req_sched #(.OQ_CREDITS(16), .BQ_CREDITS(16), .BYP_LIMIT(4)) dut (
    .iol2clk(iol2clk), .rst_l(rst_l),
    .oq_req(oq_req), .oq_wr(oq_wr), .oq_len16(oq_len16), .oq_hdr(oq_hdr),
    .oq_be(oq_be), .oq_pld(oq_pld),
    .bq_req(bq_req), .bq_wr(bq_wr), .bq_len16(bq_len16), .bq_hdr(bq_hdr),
    .bq_be(bq_be), .bq_pld(bq_pld),
    .oq_gnt(oq_gnt), .bq_gnt(bq_gnt), .oq_pld_pop(oq_pld_pop), .bq_pld_pop(bq_pld_pop),
    .sii_niu_oqdq(sii_niu_oqdq), .sii_niu_bqdq(sii_niu_bqdq),
    .niu_sii_hdr_vld(niu_sii_hdr_vld), .niu_sii_reqbypass(niu_sii_reqbypass),
    .niu_sii_datareq(niu_sii_datareq), .niu_sii_datareq16(niu_sii_datareq16),
    .niu_sii_data(niu_sii_data), .niu_sii_parity(niu_sii_parity), .niu_sii_be(niu_sii_be),
    .credit_err(credit_err), .dbg_state(dbg_state),
    .dbg_oq_credit(dbg_oq_credit), .dbg_bq_credit(dbg_bq_credit),
    .dbg_byp_streak(dbg_byp_streak)
  );

  // Clock / reset
  initial iol2clk = 1'b0;
  always #5 iol2clk = ~iol2clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  // Expected bus word: {hdr_vld, reqbypass, datareq, datareq16, be, data}
  function automatic logic [147:0] mk(input logic hv, input logic byp, input logic dr,
                                      input logic dr16, input logic [15:0] be,
                                      input logic [127:0] d);
    return {hv, byp, dr, dr16, be, d};
  endfunction

  function automatic logic [7:0] even_par(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Driver tasks
  task automatic drive_idle();
    oq_req = 0; oq_wr = 0; oq_len16 = 0; oq_hdr = '0; oq_be = '0; oq_pld = '0;
    bq_req = 0; bq_wr = 0; bq_len16 = 0; bq_hdr = '0; bq_be = '0; bq_pld = '0;
    sii_niu_oqdq = 0; sii_niu_bqdq = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_l = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge iol2clk);
    @(negedge iol2clk);
    rst_l = 1'b1;
    @(posedge iol2clk);
    #1;
  endtask

  // Scoreboard step: advance one edge, then compare the bus with the oldest expectation.
  task automatic cyc();
    logic [147:0] e, got;
    @(posedge iol2clk);
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = mk(niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16,
               niu_sii_be, niu_sii_data);
      n_checks++;
      if (got !== e || niu_sii_parity !== even_par(e[127:0])) begin
        n_fail++;
        $display("FAIL bus_word @%0t: got %h par %h exp %h par %h", $time, got,
                 niu_sii_parity, e, even_par(e[127:0]));
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst_l = 1'b0;
    repeat (2) @(posedge iol2clk);
    #1;
    n_checks++;
    if ({niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16,
         niu_sii_data, niu_sii_parity, niu_sii_be, credit_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got data %h par %h be %h err %b exp all 0",
                         niu_sii_data, niu_sii_parity, niu_sii_be, credit_err);
    end
    n_checks++;
    if (dbg_oq_credit !== 5'd16 || dbg_bq_credit !== 5'd16 || dbg_state !== 1'b0 ||
        dbg_byp_streak !== 4'd0) begin
      n_fail++; $display("FAIL reset_state: got oq %0d bq %0d st %b str %0d exp 16 16 0 0",
                         dbg_oq_credit, dbg_bq_credit, dbg_state, dbg_byp_streak);
    end
    @(negedge iol2clk);
    rst_l = 1'b1;
    @(posedge iol2clk);
    #1;
  endtask

  task automatic test_oq_read();
    do_reset();
    oq_req = 1; oq_wr = 0; oq_hdr = 128'h1;
    #1;
    n_checks++;
    if (oq_gnt !== 1'b1 || bq_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rd_gnt: got oq %b bq %b exp 1 0", oq_gnt, bq_gnt);
    end
    exp_q.push_back(mk(1, 0, 0, 0, 16'h0, 128'h1));
    cyc();
    oq_req = 0;
    n_checks++;
    if (niu_sii_parity !== 8'h01 || dbg_oq_credit !== 5'd15) begin
      n_fail++; $display("FAIL rd_par_credit: got par %h credit %0d exp 01 15",
                         niu_sii_parity, dbg_oq_credit);
    end
    exp_q.push_back(mk(0, 0, 0, 0, 16'h0, 128'h0));
    #1;
    n_checks++;
    if (oq_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rd_gnt_drop: got %b exp 0", oq_gnt);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [127:0] hdr[2];
    logic [15:0]  be[2];
    logic [127:0] beat[2][4];
    do_reset();
    for (int t = 0; t < 2; t++) begin
      hdr[t] = rnd128();
      be[t]  = 16'($urandom_range(1, 65535));
      for (int b = 0; b < 4; b++) beat[t][b] = rnd128();
    end
    for (int t = 0; t < 2; t++) begin
      bq_req = 1; bq_wr = 1; bq_len16 = 0; bq_hdr = hdr[t]; bq_be = be[t];
      bq_pld = beat[t][0];
      #1;
      n_checks++;
      if (bq_gnt !== 1'b1 || oq_gnt !== 1'b0 || bq_pld_pop !== 1'b0) begin
        n_fail++; $display("FAIL b2b_gnt%0d: got gnt %b pop %b exp 1 0", t, bq_gnt, bq_pld_pop);
      end
      exp_q.push_back(mk(1, 1, 1, 0, be[t], hdr[t]));
      cyc();
      if (t == 1) bq_req = 0;
      for (int b = 0; b < 4; b++) begin
        bq_pld = beat[t][b];
        #1;
        n_checks++;
        if (bq_pld_pop !== 1'b1 || bq_gnt !== 1'b0) begin
          n_fail++; $display("FAIL b2b_pop%0d_%0d: got pop %b gnt %b exp 1 0",
                             t, b, bq_pld_pop, bq_gnt);
        end
        exp_q.push_back(mk(0, 0, 0, 0, 16'h0, beat[t][b]));
        cyc();
      end
    end
    #1;
    n_checks++;
    if (bq_pld_pop !== 1'b0 || bq_gnt !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got pop %b gnt %b exp 0 0", bq_pld_pop, bq_gnt);
    end
    exp_q.push_back(mk(0, 0, 0, 0, 16'h0, 128'h0));
    cyc();
  endtask

  task automatic test_write16();
    logic [127:0] h, p;
    logic [15:0]  b;
    do_reset();
    for (int t = 0; t < 2; t++) begin
      h = rnd128(); p = rnd128(); b = 16'($urandom_range(1, 65535));
      oq_req = 1; oq_wr = 1; oq_len16 = 1; oq_hdr = h; oq_be = b;
      #1;
      n_checks++;
      if (oq_gnt !== 1'b1) begin
        n_fail++; $display("FAIL w16_gnt%0d: got %b exp 1", t, oq_gnt);
      end
      exp_q.push_back(mk(1, 0, 0, 1, b, h));
      cyc();
      if (t == 1) oq_req = 0;
      oq_pld = p;
      #1;
      n_checks++;
      if (oq_pld_pop !== 1'b1 || oq_gnt !== 1'b0) begin
        n_fail++; $display("FAIL w16_pop%0d: got pop %b gnt %b exp 1 0", t, oq_pld_pop, oq_gnt);
      end
      exp_q.push_back(mk(0, 0, 0, 0, 16'h0, p));
      cyc();
    end
    exp_q.push_back(mk(0, 0, 0, 0, 16'h0, 128'h0));
    cyc();
  endtask

  task automatic test_arb_pattern();
    logic exp_b;
    do_reset();
    oq_req = 1; bq_req = 1;
    for (int k = 0; k < 15; k++) begin
      oq_hdr = rnd128(); bq_hdr = rnd128();
      exp_b = (k % 5) != 4;
      #1;
      n_checks++;
      if (bq_gnt !== exp_b || oq_gnt !== !exp_b) begin
        n_fail++; $display("FAIL arb_k%0d: got bq %b oq %b exp bq %b", k, bq_gnt, oq_gnt, exp_b);
      end
      exp_q.push_back(exp_b ? mk(1, 1, 0, 0, 16'h0, bq_hdr) : mk(1, 0, 0, 0, 16'h0, oq_hdr));
      cyc();
    end
    oq_req = 0; bq_req = 0;
    n_checks++;
    if (dbg_oq_credit !== 5'd13 || dbg_bq_credit !== 5'd4) begin
      n_fail++; $display("FAIL arb_credits: got oq %0d bq %0d exp 13 4", dbg_oq_credit, dbg_bq_credit);
    end
    exp_q.push_back(mk(0, 0, 0, 0, 16'h0, 128'h0));
    cyc();
  endtask

  task automatic test_credits();
    do_reset();
    oq_req = 1;
    for (int k = 0; k < 16; k++) begin
      oq_hdr = rnd128();
      #1;
      n_checks++;
      if (oq_gnt !== 1'b1) begin
        n_fail++; $display("FAIL cred_gnt%0d: got %b exp 1", k, oq_gnt);
      end
      exp_q.push_back(mk(1, 0, 0, 0, 16'h0, oq_hdr));
      cyc();
    end
    // Out of credit: no grant, then a return pulse (counter still 0 this cycle).
    for (int k = 0; k < 2; k++) begin
      sii_niu_oqdq = (k == 1);
      #1;
      n_checks++;
      if (oq_gnt !== 1'b0) begin
        n_fail++; $display("FAIL cred_empty%0d: got %b exp 0", k, oq_gnt);
      end
      exp_q.push_back(mk(0, 0, 0, 0, 16'h0, 128'h0));
      cyc();
    end
    // Exactly one further grant, and this time a return coincides with it.
    oq_hdr = rnd128();
    #1;
    n_checks++;
    if (oq_gnt !== 1'b1) begin
      n_fail++; $display("FAIL cred_one: got %b exp 1", oq_gnt);
    end
    exp_q.push_back(mk(1, 0, 0, 0, 16'h0, oq_hdr));
    cyc();
    sii_niu_oqdq = 0;
    n_checks++;
    if (dbg_oq_credit !== 5'd1) begin
      n_fail++; $display("FAIL cred_same_cycle: got %0d exp 1", dbg_oq_credit);
    end
    oq_hdr = rnd128();
    #1;
    n_checks++;
    if (oq_gnt !== 1'b1) begin
      n_fail++; $display("FAIL cred_last: got %b exp 1", oq_gnt);
    end
    exp_q.push_back(mk(1, 0, 0, 0, 16'h0, oq_hdr));
    cyc();
    #1;
    n_checks++;
    if (oq_gnt !== 1'b0 || dbg_oq_credit !== 5'd0 || credit_err !== 1'b0) begin
      n_fail++; $display("FAIL cred_drained: got gnt %b credit %0d err %b exp 0 0 0",
                         oq_gnt, dbg_oq_credit, credit_err);
    end
    oq_req = 0;
    exp_q.push_back(mk(0, 0, 0, 0, 16'h0, 128'h0));
    cyc();
  endtask

  task automatic test_credit_err();
    do_reset();
    sii_niu_oqdq = 1;
    cyc();
    sii_niu_oqdq = 0;
    n_checks++;
    if (credit_err !== 1'b1 || dbg_oq_credit !== 5'd16) begin
      n_fail++; $display("FAIL err_set: got err %b credit %0d exp 1 16", credit_err, dbg_oq_credit);
    end
    repeat (3) cyc();
    n_checks++;
    if (credit_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b exp 1", credit_err);
    end
    do_reset();
    n_checks++;
    if (credit_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b exp 0", credit_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] h, a, b;
    do_reset();
    h = rnd128(); a = rnd128(); b = rnd128();
    bq_req = 1; bq_wr = 1; bq_len16 = 0; bq_hdr = h; bq_be = 16'hffff; bq_pld = a;
    #1;
    exp_q.push_back(mk(1, 1, 1, 0, 16'hffff, h));
    cyc();
    bq_req = 0;
    #1;
    n_checks++;
    if (bq_pld_pop !== 1'b1 || dbg_bq_credit !== 5'd15) begin
      n_fail++; $display("FAIL rm_pop1: got pop %b credit %0d exp 1 15", bq_pld_pop, dbg_bq_credit);
    end
    exp_q.push_back(mk(0, 0, 0, 0, 16'h0, a));
    cyc();
    bq_pld = b;
    #1;
    rst_l = 1'b0;
    #1;
    n_checks++;
    if ({niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16,
         niu_sii_data, niu_sii_parity, niu_sii_be, bq_pld_pop, oq_pld_pop} !== '0) begin
      n_fail++; $display("FAIL rm_outputs: got data %h par %h pop %b exp all 0",
                         niu_sii_data, niu_sii_parity, bq_pld_pop);
    end
    n_checks++;
    if (dbg_oq_credit !== 5'd16 || dbg_bq_credit !== 5'd16 || dbg_state !== 1'b0) begin
      n_fail++; $display("FAIL rm_state: got oq %0d bq %0d st %b exp 16 16 0",
                         dbg_oq_credit, dbg_bq_credit, dbg_state);
    end
    @(posedge iol2clk);
    @(negedge iol2clk);
    rst_l = 1'b1;
    @(posedge iol2clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (bq_pld_pop !== 1'b0 || bq_gnt !== 1'b0) begin
        n_fail++; $display("FAIL rm_after%0d: got pop %b gnt %b exp 0 0", k, bq_pld_pop, bq_gnt);
      end
      exp_q.push_back(mk(0, 0, 0, 0, 16'h0, 128'h0));
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_oq_read();
    test_back_to_back();
    test_write16();
    test_arb_pattern();
    test_credits();
    test_credit_err();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d left exp 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/niu_sii_req_sched.md
# niu_sii_req_sched

Request scheduler on the NIU side of the NIU→SII inbound DMA path. It arbitrates between an ordered-queue requester and a bypass-queue requester, tracks SII queue credits, and sequences each granted request onto the shared 128-bit niu_sii bus. A request is one header cycle, followed for writes by payload cycles. The block also generates per-slice parity and drives the byte enables.

## Interface
- OQ_CREDITS, 16: SII ordered-queue entries available after reset (1..31)
- BQ_CREDITS, 16: SII bypass-queue entries available after reset (1..31)
- BYP_LIMIT, 4: maximum consecutive bypass grants while an ordered request is eligible (1..15)
- iol2clk  in  1  sole clock, all state on rising edge
- rst_l  in  1  asynchronous, active-low reset
- oq_req / bq_req  in  1  request pending (level, held until gnt)
- oq_wr / bq_wr  in  1  1=DMA write, 0=DMA read
- oq_len16 / bq_len16  in  1  write only: 1=16B write (1 beat), 0=64B write (4 beats)
- oq_hdr / bq_hdr  in  128  header bits
- oq_be / bq_be  in  16  write byte enables
- oq_pld / bq_pld  in  128  current payload beat, valid from gnt until the last pop
- oq_gnt / bq_gnt  out  1  combinational; header and attributes consumed at this edge
- oq_pld_pop / bq_pld_pop  out  1  combinational; current beat consumed at this edge; advance to next beat
- sii_niu_oqdq / sii_niu_bqdq  in  1  one-cycle pulse, returns one credit
- niu_sii_hdr_vld  out  1  header cycle
- niu_sii_reqbypass  out  1  header targets bypass queue
- niu_sii_datareq  out  1  64B write header
- niu_sii_datareq16  out  1  16B write header
- niu_sii_data  out  128  header or payload
- niu_sii_parity  out  8  bit i = even parity of niu_sii_data[16i+15:16i]
- niu_sii_be  out  16  byte enables on write header cycle, else 0
- credit_err  out  1  sticky; a dq pulse arrived with counter already at its parameter value

## Operation
- All niu_sii_* outputs are registered. Reset value: every output 0, including parity. Credit counters reset to OQ_CREDITS/BQ_CREDITS. FSM resets to IDLE. Bypass streak counter resets to 0.
- FSM states:
  - IDLE: no transfer in flight.
  - PLD: counting payload pops, beats_left = 4 or 1.
- Grant is evaluated in a cycle when the FSM is IDLE, or in PLD the cycle after the last pop.
- Eligibility: x_req=1 and x credit counter > 0.
- Arbitration:
  - Bypass wins if eligible, unless the streak equals BYP_LIMIT and oq is eligible; then oq wins.
  - The streak increments on a bq grant while oq is eligible.
  - The streak clears on any oq grant, or on a bq grant with oq not eligible.
- On grant:
  - The credit counter decrements.
  - Next-cycle outputs: hdr_vld=1, data=x_hdr, reqbypass=(bq), datareq=wr&!len16, datareq16=wr&len16, be=wr?x_be:0.
  - For a write, the FSM enters PLD and x_pld_pop is asserted in the same cycle as the header cycle and each following cycle until all beats are popped. Each popped beat drives niu_sii_data on the next cycle with hdr_vld=0 and all attributes 0.
- Read: no PLD. A new grant is allowed in the header cycle, so reads can stream one header per cycle.
- Idle cycles: hdr_vld=0 and data holds 0.
- Credit return: dq increments the counter. Grant and dq in the same cycle leave the counter unchanged. A dq at the maximum value does not increment and sets credit_err.
- Only one gnt is asserted per cycle. gnt is never asserted when that queue's counter is 0.

## Timing
- Grant in cycle C → header on bus in C+1.
- 64B write: pops in C+1..C+4, beats on bus C+2..C+5. The earliest next gnt is C+5, so the next header appears at C+6 with no bubble.
- 16B write: pop in C+1, beat at C+2. The next gnt is allowed in C+2.
- Read: the next gnt is allowed in C+1, giving back-to-back headers.
- Parity and be are registered alongside data, so they are always cycle-aligned.
- Reset asserted mid-transfer: outputs go to 0 immediately (async), remaining beats are discarded, and credits are restored to the parameter values. After deassertion the requester must re-request.

## Test plan
- Reset, then oq read with hdr=128'h1: oq_gnt in C, hdr_vld=1 and data=1 in C+1, reqbypass=0, parity=8'h01, oq credit=15.
- Back-to-back 64B bq writes with beats A,B,C,D: hdr at C+1, beats C+2..C+5, bq_pld_pop high C+1..C+4, second header at C+6, datareq=1, be driven only on header cycles.
- Both requesters pending continuously with BYP_LIMIT=4: grant pattern B,B,B,B,O repeating.
- Issue 16 oq reads with no oqdq: oq_gnt stays low afterward. One oqdq pulse leads to exactly one further grant. An oqdq in the same cycle as a grant leaves the counter unchanged.
- oqdq with counter at 16: credit_err=1 and stays set until reset.
- rst_l pulsed during beat 2 of a 64B write: all outputs 0 immediately, no further pops, and both counters back to 16.
